te_block_serializer: RTL and testbench
======================================

// Module: te_block_serializer
// PURPOSE
//  Consumer/reader end of the multiple_retirement block interface.
//  - Accepts up to N trace blocks per cycle from multiple_retirement
//    (iretire, ilastsize, itype, cause, tval, priv, iaddr), compacts them in lane order and buffers them in a FIFO.
//  - Emits exactly one block per cycle to the trace encoder's single-block ingress, under a valid/ready handshake.
//  - Decouples multi-lane retirement bursts from the one-block-per-cycle encoder.
// PARAMETERS
//  N      2  number of input block lanes (matches multiple_retirement N)
//  DEPTH  8  FIFO entries; power of two, DEPTH >= N
//  Widths IRETIRE_LEN, ITYPE_LEN, CAUSE_LEN, XLEN, PRIV_LEN come from mure_pkg.
// PORTS
//  clk_i        in   1                clock
//  rst_ni       in   1                reset, asynchronous, active-low
//  valid_i      in   N                per-lane block valid
//  iretire_i    in   N*IRETIRE_LEN    per-lane retired halfword count
//  ilastsize_i  in   N                per-lane last instruction size
//  itype_i      in   N*ITYPE_LEN      per-lane block type
//  cause_i      in   N*CAUSE_LEN      per-lane exception/interrupt cause
//  tval_i       in   N*XLEN           per-lane trap value
//  priv_i       in   N*PRIV_LEN       per-lane privilege level
//  iaddr_i      in   N*XLEN           per-lane block start address
//  valid_o      out  1                output block valid (FIFO not empty)
//  ready_i      in   1                encoder accepts block this cycle
//  iretire_o    out  IRETIRE_LEN      head block fields, same meaning as inputs
//  ilastsize_o  out  1
//  itype_o      out  ITYPE_LEN
//  cause_o      out  CAUSE_LEN
//  tval_o       out  XLEN
//  priv_o       out  PRIV_LEN
//  iaddr_o      out  XLEN
//  count_o      out  $clog2(DEPTH+1)  current occupancy
//  overflow_o   out  1                1-cycle pulse: input group dropped
// BEHAVIOUR
//  Reset (async, rst_ni=0): rd/wr pointers=0, count_o=0, valid_o=0, overflow_o=0;
//   all data outputs read 0 (storage cleared).
//  Handshake:
//   - pop occurs when valid_o && ready_i at posedge.
//   - valid_o = (count != 0); data outputs = FIFO head (first-word fall-through, no
//     output register).
//   - While valid_o=1 && ready_i=0, head fields hold stable.
//  Push:
//   - k = popcount(valid_i).
//   - Valid lanes are written in ascending lane index at wr_ptr, wr_ptr+1, ...
//     Sparse valid (e.g. 2'b10) writes only lane 1, into slot wr_ptr.
//   - Latency: a block pushed at edge t is visible on outputs in cycle t+1 if the FIFO
//     was empty; there is no bypass in the same cycle.
//  Free-space check:
//   - free = DEPTH - count + (pop ? 1 : 0).
//   - If k <= free, the whole group is accepted.
//   - If k > free, the whole group is dropped (no partial write); overflow_o=1 for that
//     cycle; count changes only by the pop.
//  Simultaneous push and pop: count_next = count + k - pop. Legal at full (pop frees
//   one slot for push).
//  Pointers: log2(DEPTH) bits, natural wrap-around modulo DEPTH; a multi-lane write may
//   straddle the wrap (slot DEPTH-1, then 0).
//  Empty: ready_i is ignored; no pop; pointers unchanged.
//  No combinational path from ready_i to any output except through count/pointer
//   registers; valid_i does not affect outputs in the same cycle.
//  Reset mid-burst: all contents discarded; outputs return to reset values immediately
//   (asynchronous).
// TESTING (N=2, DEPTH=4)
//  T1 reset: rst_ni=0 with valid_i=2'b11 -> valid_o=0, count_o=0, overflow_o=0
//   throughout; after release the first push is seen one cycle later.
//  T2 order: valid_i=2'b11, lane0 iaddr=0x100, lane1 iaddr=0x200, ready_i=1 ->
//   iaddr_o=0x100 next cycle, 0x200 the cycle after, then valid_o=0.
//  T3 sparse lane: valid_i=2'b10, lane1 itype=2, cause=5 -> one entry; itype_o=2,
//   cause_o=5; count_o=1.
//  T4 backpressure/overflow: ready_i=0; push 2'b11 twice -> count_o=4; a third push
//   2'b01 -> overflow_o=1 for 1 cycle, count_o stays 4, head unchanged.
//  T5 full with pop: count=4, ready_i=1, valid_i=2'b01 -> accepted, count_o stays 4,
//   no overflow; valid_i=2'b11 at count=4 with pop -> dropped, overflow_o=1, count_o=3.
//  T6 wrap: stream 10 groups of 2'b11 with ready_i=1 and iaddr 0x0,0x4,...,0x4C ->
//   output iaddr sequence matches in order, occupancy never exceeds 4, no overflow
//   while draining keeps pace.

Source files
------------

// File: rtl/te_block_serializer.sv
// te_block_serializer: compacts up to N valid trace-block lanes per cycle into a FIFO
// and presents them one block at a time on a valid/ready single-block port.
module te_block_serializer #(
    parameter int N           = 2,
    parameter int DEPTH       = 8,
    parameter int IRETIRE_LEN = 7,
    parameter int ITYPE_LEN   = 3,
    parameter int CAUSE_LEN   = 5,
    parameter int XLEN        = 32,
    parameter int PRIV_LEN    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N-1:0]                 valid_i,
    input  logic [N*IRETIRE_LEN-1:0]     iretire_i,
    input  logic [N-1:0]                 ilastsize_i,
    input  logic [N*ITYPE_LEN-1:0]       itype_i,
    input  logic [N*CAUSE_LEN-1:0]       cause_i,
    input  logic [N*XLEN-1:0]            tval_i,
    input  logic [N*PRIV_LEN-1:0]        priv_i,
    input  logic [N*XLEN-1:0]            iaddr_i,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [IRETIRE_LEN-1:0]       iretire_o,
    output logic                         ilastsize_o,
    output logic [ITYPE_LEN-1:0]         itype_o,
    output logic [CAUSE_LEN-1:0]         cause_o,
    output logic [XLEN-1:0]              tval_o,
    output logic [PRIV_LEN-1:0]          priv_o,
    output logic [XLEN-1:0]              iaddr_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = IRETIRE_LEN + 1 + ITYPE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + XLEN;

    typedef logic [EW-1:0] entry_t;

    entry_t           mem [DEPTH];
    entry_t           lane_entry [N];
    logic [PTR_W-1:0] lane_slot [N];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] k;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] count_next;
    logic             pop;
    logic             accept;

    // Each valid lane lands at wr_ptr plus the number of valid lanes below it.
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            lane_entry[i] = {iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN],
                             ilastsize_i[i],
                             itype_i[i*ITYPE_LEN +: ITYPE_LEN],
                             cause_i[i*CAUSE_LEN +: CAUSE_LEN],
                             tval_i[i*XLEN +: XLEN],
                             priv_i[i*PRIV_LEN +: PRIV_LEN],
                             iaddr_i[i*XLEN +: XLEN]};
            lane_slot[i]  = wr_ptr + PTR_W'(k);
            k             = k + CNT_W'(valid_i[i]);
        end
    end

    // A pop in the same cycle frees one slot for the incoming group.
    always_comb begin
        pop        = (count_q != '0) && ready_i;
        free       = CNT_W'(DEPTH) - count_q + CNT_W'(pop);
        accept     = (k <= free);
        count_next = count_q + (accept ? k : '0) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                mem[s] <= '0;
            end
        end else begin
            if (accept) begin
                for (int i = 0; i < N; i++) begin
                    if (valid_i[i]) begin
                        mem[lane_slot[i]] <= lane_entry[i];
                    end
                end
                wr_ptr <= wr_ptr + PTR_W'(k);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q    <= count_next;
            overflow_o <= !accept;
        end
    end

    // First-word fall-through: the head slot drives the outputs directly.
    assign {iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o} = mem[rd_ptr];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Randomized scoreboard bench for te_block_serializer: a queue-based reference model
// predicts occupancy, overflow and the output block stream.
module tb_te_block_serializer;

    localparam int N           = 2;
    localparam int DEPTH       = 4;
    localparam int IRETIRE_LEN = 7;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int XLEN        = 32;
    localparam int PRIV_LEN    = 2;
    localparam int CNT_W       = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } blk_t;

    typedef struct packed {
        logic             vld;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } stat_t;

    logic                     clk_i;
    logic                     rst_ni;
    logic [N-1:0]             valid_i;
    logic [N*IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]             ilastsize_i;
    logic [N*ITYPE_LEN-1:0]   itype_i;
    logic [N*CAUSE_LEN-1:0]   cause_i;
    logic [N*XLEN-1:0]        tval_i;
    logic [N*PRIV_LEN-1:0]    priv_i;
    logic [N*XLEN-1:0]        iaddr_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [IRETIRE_LEN-1:0]   iretire_o;
    logic                     ilastsize_o;
    logic [ITYPE_LEN-1:0]     itype_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
    logic [PRIV_LEN-1:0]      priv_o;
    logic [XLEN-1:0]          iaddr_o;
    logic [CNT_W-1:0]         count_o;
    logic                     overflow_o;

    blk_t  lane_e [N];
    blk_t  exp_q [$];
    stat_t stat_q [$];
    stat_t mon_s;
    blk_t  mon_h;
    int    m_cnt;
    bit    chk_en;
    int    n_vec;
    int    n_err;

    te_block_serializer #(
        .N(N), .DEPTH(DEPTH), .IRETIRE_LEN(IRETIRE_LEN), .ITYPE_LEN(ITYPE_LEN),
        .CAUSE_LEN(CAUSE_LEN), .XLEN(XLEN), .PRIV_LEN(PRIV_LEN)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
        .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i), .iaddr_i(iaddr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
        .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o), .iaddr_o(iaddr_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic blk_t rand_blk();
        blk_t b;
        b.iretire   = IRETIRE_LEN'($urandom);
        b.ilastsize = 1'($urandom);
        b.itype     = ITYPE_LEN'($urandom);
        b.cause     = CAUSE_LEN'($urandom);
        b.tval      = $urandom;
        b.priv      = PRIV_LEN'($urandom);
        b.iaddr     = $urandom;
        return b;
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic rdy);
        valid_i = v;
        ready_i = rdy;
        for (int i = 0; i < N; i++) begin
            iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN] = lane_e[i].iretire;
            ilastsize_i[i]                          = lane_e[i].ilastsize;
            itype_i[i*ITYPE_LEN +: ITYPE_LEN]       = lane_e[i].itype;
            cause_i[i*CAUSE_LEN +: CAUSE_LEN]       = lane_e[i].cause;
            tval_i[i*XLEN +: XLEN]                  = lane_e[i].tval;
            priv_i[i*PRIV_LEN +: PRIV_LEN]          = lane_e[i].priv;
            iaddr_i[i*XLEN +: XLEN]                 = lane_e[i].iaddr;
        end
    endtask

    // Reference model: a group of k blocks fits if k <= DEPTH - occupancy (+1 on a pop).
    task automatic step(input logic [N-1:0] v, input logic rdy);
        int    k;
        int    free;
        bit    pop;
        stat_t s;
        drive(v, rdy);
        pop  = (m_cnt > 0) && rdy;
        k    = $countones(v);
        free = DEPTH - m_cnt + (pop ? 1 : 0);
        if (k <= free) begin
            for (int i = 0; i < N; i++) begin
                if (v[i]) exp_q.push_back(lane_e[i]);
            end
            m_cnt += k;
        end
        if (pop) m_cnt--;
        s.vld = (m_cnt != 0);
        s.cnt = CNT_W'(m_cnt);
        s.ovf = (k > free);
        stat_q.push_back(s);
        @(posedge clk_i);
        #1;
    endtask

    task automatic restart();
        stat_t s;
        exp_q.delete();
        stat_q.delete();
        m_cnt = 0;
        s     = '0;
        stat_q.push_back(s);
        chk_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_o"}, valid_o, 0);
        check({tag, "_count_o"}, count_o, 0);
        check({tag, "_overflow_o"}, overflow_o, 0);
        check({tag, "_iaddr_o"}, iaddr_o, 0);
        check({tag, "_itype_o"}, itype_o, 0);
    endtask

    // Monitor: per-cycle status plus head-of-FIFO comparison against the scoreboard.
    always @(negedge clk_i) begin
        if (chk_en) begin
            if (stat_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL status: no expectation queued, got count %0d", count_o);
            end else begin
                mon_s = stat_q.pop_front();
                check("valid_o", valid_o, mon_s.vld);
                check("count_o", count_o, mon_s.cnt);
                check("overflow_o", overflow_o, mon_s.ovf);
            end
            if (valid_o) begin
                mon_h = {iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL head: unexpected block, got iaddr %0h, expected none", iaddr_o);
                end else begin
                    if (mon_h !== exp_q[0]) begin
                        n_err++;
                        $display("FAIL head: got %0h, expected %0h", mon_h, exp_q[0]);
                    end
                    if (ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        chk_en = 1'b0;
        m_cnt  = 0;
        rst_ni = 1'b0;
        for (int i = 0; i < N; i++) lane_e[i] = rand_blk();
        drive(2'b11, 1'b1);

        // T1: inputs active during reset must not reach the outputs
        repeat (3) begin
            @(negedge clk_i);
            check_reset_outputs("reset");
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        restart();

        // T2: lane order, first push visible one cycle later
        lane_e[0] = rand_blk();
        lane_e[1] = rand_blk();
        lane_e[0].iaddr = 32'h100;
        lane_e[1].iaddr = 32'h200;
        step(2'b11, 1'b1);
        repeat (3) step(2'b00, 1'b1);

        // T3: sparse lane 1 only
        lane_e[0] = rand_blk();
        lane_e[1] = rand_blk();
        lane_e[1].itype = 3'd2;
        lane_e[1].cause = 5'd5;
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);
        check("sparse_itype_o", itype_o, 2);
        check("sparse_cause_o", cause_o, 5);
        repeat (2) step(2'b00, 1'b1);

        // T4: backpressure until full, then an overflowing group
        repeat (2) begin
            for (int i = 0; i < N; i++) lane_e[i] = rand_blk();
            step(2'b11, 1'b0);
        end
        lane_e[0] = rand_blk();
        step(2'b01, 1'b0);
        repeat (2) step(2'b00, 1'b0);

        // T5: full with pop accepts one, drops two
        lane_e[0] = rand_blk();
        step(2'b01, 1'b1);
        for (int i = 0; i < N; i++) lane_e[i] = rand_blk();
        step(2'b11, 1'b1);
        repeat (DEPTH + 1) step(2'b00, 1'b1);

        // T6: streamed groups wrap the pointers
        for (int g = 0; g < 10; g++) begin
            lane_e[0] = rand_blk();
            lane_e[1] = rand_blk();
            lane_e[0].iaddr = 32'(g * 8);
            lane_e[1].iaddr = 32'(g * 8 + 4);
            step(2'b11, 1'b1);
            step(2'b00, 1'b1);
        end
        repeat (DEPTH + 1) step(2'b00, 1'b1);

        // Reset in the middle of a backpressured burst
        repeat (2) begin
            for (int i = 0; i < N; i++) lane_e[i] = rand_blk();
            step(2'b11, 1'b0);
        end
        chk_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk_i);
        #1;
        check_reset_outputs("held_reset");
        rst_ni = 1'b1;
        restart();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) lane_e[i] = rand_blk();
            step(N'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (DEPTH + 2) step(2'b00, 1'b1);

        @(negedge clk_i);
        #1;
        chk_en = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
